// File: rtl/corridor_plant.sv
// Corridor environment model for the passageway monitor: Mealy look-ahead observations of the next state.
// Optional fault injection is built only when CORRIDOR_FAULT_INJ_EN is defined.
module corridor_plant #(
   parameter int unsigned NZONES       = 10,
   parameter int unsigned DOOR_HOLD    = 4,
   parameter int unsigned STEP_LIMIT   = 255,
   parameter int unsigned FAULT_PERIOD = 100
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            act_valid,
   input  logic                            up,
   input  logic                            right,
   output logic [NZONES-1:0]               zone,
   output logic                            open,
   output logic                            doorstep,
   output logic                            fault,
   output logic                            at_goal,
   output logic                            timeout,
   output logic [$clog2(STEP_LIMIT+1)-1:0] steps
);

   localparam int unsigned ZW = (NZONES > 1) ? $clog2(NZONES) : 1;
   localparam int unsigned HW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
   localparam int unsigned SW = $clog2(STEP_LIMIT + 1);

   typedef enum logic [1:0] {CLOSED, OPEN, DSTEP, GOAL} mode_t;

   mode_t          mode_q, mode_d;
   logic [ZW-1:0]  zidx_q, zidx_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [SW-1:0]  steps_q, steps_d;
   logic           at_goal_q, timeout_q, fault_q;

   always_comb begin
      mode_d  = mode_q;
      zidx_d  = zidx_q;
      hold_d  = hold_q;
      steps_d = steps_q;
      if (act_valid) begin
         if (steps_q != SW'(STEP_LIMIT)) steps_d = steps_q + 1'b1;
         case (mode_q)
            CLOSED: begin
               if (!up && right) begin
                  mode_d = OPEN;
                  hold_d = '0;
               end
            end
            OPEN: begin
               if (up) begin
                  mode_d = CLOSED;
               end else if (right) begin
                  mode_d = DSTEP;
               end else if (hold_q == HW'(DOOR_HOLD - 1)) begin
                  mode_d = CLOSED;
                  hold_d = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            DSTEP: begin
               mode_d = OPEN;
               hold_d = '0;
               if (right) begin
                  zidx_d = zidx_q + 1'b1;
                  if (zidx_q == ZW'(NZONES - 2)) mode_d = GOAL;
               end else if (zidx_q != '0) begin
                  zidx_d = zidx_q - 1'b1;
               end
            end
            GOAL: begin
            end
            default: begin
            end
         endcase
      end
   end

   // Decoding next state gives look-ahead when act_valid is high and current state otherwise.
   always_comb begin
      zone     = rst_n ? (NZONES'(1) << zidx_d) : NZONES'(1);
      open     = rst_n && (mode_d != CLOSED);
      doorstep = rst_n && (mode_d == DSTEP);
      fault    = rst_n && fault_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q    <= CLOSED;
         zidx_q    <= '0;
         hold_q    <= '0;
         steps_q   <= '0;
         at_goal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         zidx_q    <= zidx_d;
         hold_q    <= hold_d;
         steps_q   <= steps_d;
         at_goal_q <= (mode_d == GOAL);
         if (steps_d == SW'(STEP_LIMIT)) timeout_q <= 1'b1;
      end
   end

`ifdef CORRIDOR_FAULT_INJ_EN
   logic [15:0] fcnt_q, fcnt_d;

   always_comb begin
      fcnt_d = fcnt_q;
      if (act_valid && (fcnt_q != '1)) fcnt_d = fcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         fcnt_q <= fcnt_d;
         if (fcnt_d == 16'(FAULT_PERIOD)) fault_q <= 1'b1;
      end
   end
`else
   logic unused_fault_period;
   assign unused_fault_period = ^FAULT_PERIOD;
   assign fault_q = 1'b0;
`endif

   assign at_goal = at_goal_q;
   assign timeout = timeout_q;
   assign steps   = steps_q;

endmodule

// File: tb/tb_corridor_plant.sv
// Self-checking bench for corridor_plant: directed vector table, hand sequences and a random stream
// compared against a behavioural corridor model.
module tb_corridor_plant;

   localparam int unsigned NZ = 10;
   localparam int unsigned DH = 4;
   localparam int unsigned SL = 255;
   localparam int unsigned FP = 100;
`ifdef CORRIDOR_FAULT_INJ_EN
   localparam bit FAULT_ON = 1'b1;
`else
   localparam bit FAULT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, act_valid, up, right;
   logic [NZ-1:0] zone;
   logic          open, doorstep, fault, at_goal, timeout;
   logic [7:0]    steps;

   always #5 clk = ~clk;

   corridor_plant #(
      .NZONES(NZ), .DOOR_HOLD(DH), .STEP_LIMIT(SL), .FAULT_PERIOD(FP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .act_valid(act_valid), .up(up), .right(right),
      .zone(zone), .open(open), .doorstep(doorstep), .fault(fault),
      .at_goal(at_goal), .timeout(timeout), .steps(steps)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: where the agent stands and whether the door is open.
   int m_zone, m_wait, m_steps, m_acc;
   bit m_door, m_step, m_goal, m_timeout;

   typedef struct {
      bit          av, u, r;
      logic [NZ-1:0] zone;
      bit          open, ds;
   } vec_t;
   vec_t tbl[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_fault();
      return FAULT_ON && (m_acc >= int'(FP));
   endfunction

   task automatic model_reset();
      m_zone = 0; m_wait = 0; m_steps = 0; m_acc = 0;
      m_door = 0; m_step = 0; m_goal = 0; m_timeout = 0;
   endtask

   task automatic model_advance(input bit u, input bit r);
      if (m_goal) begin
      end else if (m_step) begin
         m_step = 0;
         m_wait = 0;
         if (r) begin
            m_zone = m_zone + 1;
            if (m_zone == int'(NZ) - 1) m_goal = 1;
         end else if (m_zone > 0) begin
            m_zone = m_zone - 1;
         end
      end else if (m_door) begin
         if (u) m_door = 0;
         else if (r) m_step = 1;
         else if (m_wait + 1 == int'(DH)) m_door = 0;
         else m_wait = m_wait + 1;
      end else if (!u && r) begin
         m_door = 1;
         m_wait = 0;
      end
   endtask

   // Called one time unit after a rising edge; samples combinational outputs before the next edge.
   task automatic drive(input bit av, input bit u, input bit r);
      act_valid = av; up = u; right = r;
      if (av) begin
         model_advance(u, r);
         if (m_steps < int'(SL)) m_steps++;
         if (m_acc < 65535) m_acc++;
      end
      #4;
      chk("zone", 32'(zone), 32'(1) << m_zone);
      chk("open", 32'(open), 32'(m_door || m_step || m_goal));
      chk("doorstep", 32'(doorstep), 32'(m_step));
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      #1;
      if (m_steps == int'(SL)) m_timeout = 1;
      chk("steps", 32'(steps), 32'(m_steps));
      chk("at_goal", 32'(at_goal), 32'(m_goal));
      chk("timeout", 32'(timeout), 32'(m_timeout));
      chk("fault", 32'(fault), 32'(exp_fault()));
   endtask

   task automatic apply(input bit av, input bit u, input bit r);
      drive(av, u, r);
      finish_cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      act_valid = 1'($urandom); up = 1'($urandom); right = 1'($urandom);
      #4;
      chk("rst_zone", 32'(zone), 32'd1);
      chk("rst_open", 32'(open), 32'd0);
      chk("rst_doorstep", 32'(doorstep), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      chk("rst_steps", 32'(steps), 32'd0);
      chk("rst_at_goal", 32'(at_goal), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] held;

      tbl[0]  = '{1'b1, 1'b1, 1'b0, 10'h001, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 10'h001, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 10'h001, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 10'h001, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 10'h001, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 10'h001, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 10'h001, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 10'h002, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 10'h002, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 1'b1, 10'h004, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 1'b1, 10'h004, 1'b1, 1'b1};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 10'h008, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 1'b0, 1'b1, 10'h008, 1'b1, 1'b1};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 10'h004, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 1'b1, 1'b1, 10'h004, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 1'b1, 10'h004, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 1'b1, 1'b0, 10'h004, 1'b1, 1'b0};
      tbl[23] = '{1'b1, 1'b1, 1'b0, 10'h004, 1'b0, 1'b0};
      tbl[24] = '{1'b0, 1'b0, 1'b1, 10'h004, 1'b0, 1'b0};

      // Directed vector table from reset.
      do_reset();
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].av, tbl[i].u, tbl[i].r);
         chk($sformatf("tbl%0d_zone", i), 32'(zone), 32'(tbl[i].zone));
         chk($sformatf("tbl%0d_open", i), 32'(open), 32'(tbl[i].open));
         chk($sformatf("tbl%0d_doorstep", i), 32'(doorstep), 32'(tbl[i].ds));
         finish_cycle();
         if (i == 2) chk("steps_after_3_up", 32'(steps), 32'd3);
      end
      chk("tbl_steps_total", 32'(steps), 32'd21);

      // Walk the open-door path to the goal, then show the goal is absorbing.
      do_reset();
      for (int i = 0; i < 27; i++) apply(1'b1, 1'b0, 1'b1);
      chk("goal_at_goal", 32'(at_goal), 32'd1);
      chk("goal_steps", 32'(steps), 32'd27);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'($urandom), 1'($urandom));
         chk("goal_zone_held", 32'(zone), 32'h200);
         chk("goal_open_held", 32'(open), 32'd1);
         chk("goal_doorstep_held", 32'(doorstep), 32'd0);
         finish_cycle();
      end
      do_reset();
      apply(1'b0, 1'b0, 1'b0);
      chk("goal_cleared_by_reset", 32'(at_goal), 32'd0);

      // Idle cycles freeze everything; mid-episode reset in OPEN at zone 5.
      do_reset();
      for (int i = 0; i < 11; i++) apply(1'b1, 1'b0, 1'b1);
      chk("z5_zone", 32'(zone), 32'h020);
      held = steps;
      for (int i = 0; i < 5; i++) apply(1'b0, 1'(i), 1'(i >> 1));
      chk("idle_steps_held", 32'(steps), 32'd11);
      chk("idle_zone_held", 32'(zone), 32'h020);
      chk("idle_open_held", 32'(open), 32'd1);
      do_reset();
      drive(1'b0, 1'b0, 1'b1);
      chk("after_rst_zone", 32'(zone), 32'd1);
      chk("after_rst_open", 32'(open), 32'd0);
      finish_cycle();

      // Step counter saturation and sticky timeout.
      do_reset();
      for (int i = 0; i < 254; i++) apply(1'b1, 1'($urandom), 1'($urandom));
      chk("pre_limit_steps", 32'(steps), 32'd254);
      chk("pre_limit_timeout", 32'(timeout), 32'd0);
      apply(1'b1, 1'b1, 1'b0);
      apply(1'b0, 1'b0, 1'b0);
      chk("limit_steps", 32'(steps), 32'd255);
      chk("limit_timeout", 32'(timeout), 32'd1);
      apply(1'b1, 1'b0, 1'b1);
      chk("sat_steps", 32'(steps), 32'd255);

      // Random action stream against the model.
      do_reset();
      for (int i = 0; i < 500; i++)
         apply(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
